// File: rtl/ctrl_dataflow_sequencer.sv
// Systolic-array dataflow sequencer: turns the controller step count into
// registered feed, accumulate, write-back and done controls, and checks the step order.
module ctrl_dataflow_sequencer #(
   parameter int N  = 16,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [5:0]      state_count,
   input  logic            end_signal,
   input  logic            done_ready,
   output logic [N-1:0]    feed_en,
   output logic [N*AW-1:0] feed_addr,
   output logic            acc_clr,
   output logic            wb_en,
   output logic [AW-1:0]   wb_row,
   output logic            busy,
   output logic            done_valid,
   output logic            seq_err
);

   localparam logic [5:0] LP_LAST = 6'(3*N+1);
   localparam logic [5:0] LP_WB0  = 6'(2*N);
   localparam logic [5:0] LP_WB1  = 6'(3*N-1);
   localparam logic [5:0] LP_FIN  = 6'd63;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DONE  = 2'd1,
      S_ACKED = 2'd2
   } done_state_t;

   done_state_t r_state, w_state_nxt;

   logic [5:0]      r_prev;
   logic [5:0]      w_k;
   logic            w_run;
   logic            w_seq_ok;
   logic [N-1:0]    w_feed_en;
   logic [N*AW-1:0] w_feed_addr;
   logic            w_wb_en;
   logic [AW-1:0]   w_wb_row;

   always_comb begin
      w_run       = (state_count != 6'd0) && (state_count <= LP_LAST);
      w_k         = state_count - 6'd1;
      w_feed_en   = '0;
      w_feed_addr = '0;
      // Row i is skewed by i cycles and streams N operands.
      for (int i = 0; i < N; i++) begin
         if (w_run && (w_k >= 6'(i)) && (w_k <= 6'(i+N-1))) begin
            w_feed_en[i]            = 1'b1;
            w_feed_addr[i*AW +: AW] = AW'(w_k - 6'(i));
         end
      end
      w_wb_en  = w_run && (w_k >= LP_WB0) && (w_k <= LP_WB1);
      w_wb_row = w_wb_en ? AW'(w_k - LP_WB0) : '0;
      w_seq_ok = (state_count == r_prev)
              || ((r_prev < LP_LAST) && (state_count == r_prev + 6'd1))
              || ((r_prev == LP_LAST) && (state_count == LP_FIN));
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (end_signal) w_state_nxt = S_DONE;
         S_DONE:  if (done_ready) w_state_nxt = S_ACKED;
         S_ACKED: w_state_nxt = S_ACKED;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_prev     <= 6'd0;
         feed_en    <= '0;
         feed_addr  <= '0;
         acc_clr    <= 1'b1;
         wb_en      <= 1'b0;
         wb_row     <= '0;
         busy       <= 1'b0;
         done_valid <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prev     <= state_count;
         feed_en    <= w_feed_en;
         feed_addr  <= w_feed_addr;
         acc_clr    <= (state_count == 6'd0);
         wb_en      <= w_wb_en;
         wb_row     <= w_wb_row;
         busy       <= w_run;
         done_valid <= (w_state_nxt == S_DONE);
         if (!w_seq_ok) seq_err <= 1'b1;
      end
   end

endmodule
